// File: rtl/afe_spi_ctrl.sv
// SPI master carrying AFE register writes and reads: one {rw, addr, data} frame per
// command, CPOL=0, MSB first, with a one-cycle response strobe for read data.
module afe_spi_ctrl #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_rw_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  busy_o,
    output logic                  spi_clk_o,
    output logic                  spi_mosi_o,
    input  logic                  spi_miso_i,
    output logic                  spi_sen_o
);

    localparam int unsigned FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    state_e                state_q,     state_d;
    logic [PH_W-1:0]       phase_q,     phase_d;
    logic [BIT_W-1:0]      bit_q,       bit_d;
    logic                  high_q,      high_d;
    logic [FRAME_W-1:0]    tx_q,        tx_d;
    logic [DATA_WIDTH-1:0] rx_q,        rx_d;
    logic                  rd_q,        rd_d;
    logic                  ready_q,     ready_d;
    logic                  busy_q,      busy_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic                  sclk_q,      sclk_d;
    logic                  mosi_q,      mosi_d;
    logic                  sen_q,       sen_d;
    logic                  phase_last_c;

    assign phase_last_c = (phase_q == PH_LAST);

    // Next-state and registered-output logic; outputs are computed for the coming cycle.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        high_d      = high_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rd_d        = rd_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        sen_d       = sen_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    state_d = ST_SETUP;
                    phase_d = '0;
                    tx_d    = {cmd_rw_i, cmd_addr_i,
                               (cmd_rw_i ? DATA_WIDTH'(0) : cmd_data_i)};
                    rd_d    = cmd_rw_i;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    sen_d   = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = cmd_rw_i;
                end
            end

            ST_SETUP: begin
                if (phase_last_c) begin
                    state_d = ST_SHIFT;
                    phase_d = '0;
                    bit_d   = '0;
                    high_d  = 1'b0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            ST_SHIFT: begin
                // MISO is taken in the first cycle SCLK is high.
                if (high_q && (phase_q == '0)) begin
                    rx_d = DATA_WIDTH'({rx_q, spi_miso_i});
                end
                if (phase_last_c) begin
                    phase_d = '0;
                    if (!high_q) begin
                        high_d = 1'b1;
                        sclk_d = 1'b1;
                    end else begin
                        high_d = 1'b0;
                        sclk_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_HOLD;
                            mosi_d  = 1'b0;
                        end else begin
                            bit_d  = bit_q + BIT_W'(1);
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[FRAME_W-2];
                        end
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            ST_HOLD: begin
                if (phase_last_c) begin
                    state_d = ST_GAP;
                    phase_d = '0;
                    sen_d   = 1'b1;
                    if (rd_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rx_q;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            ST_GAP: begin
                if (phase_last_c) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                sen_d   = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // Asynchronous reset abandons any frame: SEN high and SCLK low at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            high_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            rd_q        <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            sen_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            high_q      <= high_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rd_q        <= rd_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            sen_q       <= sen_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign spi_clk_o   = sclk_q;
    assign spi_mosi_o  = mosi_q;
    assign spi_sen_o   = sen_q;

endmodule

// File: tb/tb_afe_spi_ctrl.sv
// Directed bench for afe_spi_ctrl: default divider instance plus a CLK_DIV=1 instance.
module tb_afe_spi_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid0, cmd_valid1;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       miso;

    logic       ready0, rsp_valid0, busy0, sclk0, mosi0, sen0;
    logic [7:0] rsp_data0;
    logic       ready1, rsp_valid1, busy1, sclk1, mosi1, sen1;
    logic [7:0] rsp_data1;

    int total = 0;
    int bad   = 0;

    logic [15:0] r_mosi;
    logic [7:0]  r_rsp;
    logic        r_rdy_first;
    int r_nclk, r_sen_low, r_nrsp, r_lat, r_first, r_gap, r_pmin, r_pmax, r_rsp_rise;

    always #5 clk = ~clk;

    afe_spi_ctrl #(.CLK_DIV(4), .ADDR_WIDTH(7), .DATA_WIDTH(8)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid_i(cmd_valid0), .cmd_ready_o(ready0),
        .cmd_rw_i(cmd_rw), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid0), .rsp_data_o(rsp_data0), .busy_o(busy0),
        .spi_clk_o(sclk0), .spi_mosi_o(mosi0), .spi_miso_i(miso), .spi_sen_o(sen0)
    );

    afe_spi_ctrl #(.CLK_DIV(1), .ADDR_WIDTH(7), .DATA_WIDTH(8)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid_i(cmd_valid1), .cmd_ready_o(ready1),
        .cmd_rw_i(cmd_rw), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid1), .rsp_data_o(rsp_data1), .busy_o(busy1),
        .spi_clk_o(sclk1), .spi_mosi_o(mosi1), .spi_miso_i(miso), .spi_sen_o(sen1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Runs one frame on the selected instance, acting as the AFE for MISO.
    task automatic do_frame(input int sel, input logic rw, input logic [6:0] addr,
                            input logic [7:0] data, input logic [7:0] miso_byte,
                            input logic chain, input logic [15:0] nxt);
        logic s_sclk, s_mosi, s_sen, s_rdy, s_rv, p_sclk, p_sen;
        logic [7:0] s_rd;
        int last_rise;
        bit done;
        cmd_rw   = rw;
        cmd_addr = addr;
        cmd_data = data;
        if (sel == 0) cmd_valid0 = 1'b1; else cmd_valid1 = 1'b1;
        r_mosi = '0; r_rsp = '0; r_rdy_first = 1'b1;
        r_nclk = 0; r_sen_low = 0; r_nrsp = 0; r_lat = -1; r_first = -1;
        r_gap = 0; r_pmin = 1000; r_pmax = 0; r_rsp_rise = 0;
        p_sclk = 1'b0; p_sen = 1'b1; last_rise = -1; done = 0;
        for (int n = 1; n <= 400 && !done; n++) begin
            @(posedge clk);
            #1;
            s_sclk = (sel == 0) ? sclk0      : sclk1;
            s_mosi = (sel == 0) ? mosi0      : mosi1;
            s_sen  = (sel == 0) ? sen0       : sen1;
            s_rdy  = (sel == 0) ? ready0     : ready1;
            s_rv   = (sel == 0) ? rsp_valid0 : rsp_valid1;
            s_rd   = (sel == 0) ? rsp_data0  : rsp_data1;
            if (n == 1) begin
                r_rdy_first = s_rdy;
                if (chain) {cmd_rw, cmd_addr, cmd_data} = nxt;
                else begin
                    cmd_valid0 = 1'b0;
                    cmd_valid1 = 1'b0;
                    cmd_addr   = ~addr;
                    cmd_data   = ~data;
                end
            end
            if (!s_sen) begin
                r_sen_low++;
                if (r_first < 0) r_first = n;
            end
            if (s_sclk && !p_sclk) begin
                r_mosi = {r_mosi[14:0], s_mosi};
                r_nclk++;
                if (last_rise >= 0) begin
                    if (n - last_rise < r_pmin) r_pmin = n - last_rise;
                    if (n - last_rise > r_pmax) r_pmax = n - last_rise;
                end
                last_rise = n;
            end
            if (s_rv) begin
                r_nrsp++;
                r_rsp = s_rd;
                if (s_sen && !p_sen) r_rsp_rise++;
            end
            r_gap = s_sen ? r_gap + 1 : 0;
            if (!s_sclk && !s_sen && r_nclk < 16)
                miso = (r_nclk >= 8) ? miso_byte[3'(15 - r_nclk)] : 1'b1;
            if (r_first >= 0 && s_rdy) begin
                done  = 1;
                r_lat = n - r_first;
            end
            p_sclk = s_sclk;
            p_sen  = s_sen;
        end
        chk("frame_done", 32'(done), 32'd1);
    endtask

    initial begin
        int rises;
        int rv_seen;
        int sen_lo;
        reset_n    = 1'b0;
        cmd_valid0 = 1'b0;
        cmd_valid1 = 1'b0;
        cmd_rw     = 1'b0;
        cmd_addr   = '0;
        cmd_data   = '0;
        miso       = 1'b0;

        // Reset while idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready0), 32'd1);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data0), 32'd0);
        chk("rst_sclk", 32'(sclk0), 32'd0);
        chk("rst_mosi", 32'(mosi0), 32'd0);
        chk("rst_sen", 32'(sen0), 32'd1);
        reset_n = 1'b1;
        sen_lo = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!sen0) sen_lo++;
        end
        chk("idle_sen_low_cycles", 32'(sen_lo), 32'd0);
        chk("idle_ready", 32'(ready0), 32'd1);

        // Write 15/A5
        do_frame(0, 1'b0, 7'h15, 8'hA5, 8'h00, 1'b0, 16'h0);
        chk("wr_ready_drop", 32'(r_rdy_first), 32'd0);
        chk("wr_first_sen", 32'(r_first), 32'd1);
        chk("wr_mosi", 32'(r_mosi), 32'h15A5);
        chk("wr_sclk_pulses", 32'(r_nclk), 32'd16);
        chk("wr_sen_low", 32'(r_sen_low), 32'd136);
        chk("wr_no_rsp", 32'(r_nrsp), 32'd0);
        chk("wr_latency", 32'(r_lat), 32'd140);
        chk("wr_sclk_period", 32'(r_pmax), 32'd8);
        chk("wr_rsp_data_kept", 32'(rsp_data0), 32'd0);

        // Read 02, AFE returns 3C
        do_frame(0, 1'b1, 7'h02, 8'hFF, 8'h3C, 1'b0, 16'h0);
        chk("rd_mosi", 32'(r_mosi), 32'h8200);
        chk("rd_sen_low", 32'(r_sen_low), 32'd136);
        chk("rd_rsp_count", 32'(r_nrsp), 32'd1);
        chk("rd_rsp_at_sen_rise", 32'(r_rsp_rise), 32'd1);
        chk("rd_rsp_value", 32'(r_rsp), 32'h3C);
        chk("rd_rsp_held", 32'(rsp_data0), 32'h3C);
        chk("rd_latency", 32'(r_lat), 32'd140);

        // Back-to-back: write 7E/81 then read 2B returning 96
        do_frame(0, 1'b0, 7'h7E, 8'h81, 8'h00, 1'b1, {1'b1, 7'h2B, 8'h44});
        chk("b2b_a_mosi", 32'(r_mosi), 32'h7E81);
        chk("b2b_a_no_rsp", 32'(r_nrsp), 32'd0);
        chk("b2b_a_rsp_data_kept", 32'(rsp_data0), 32'h3C);
        chk("b2b_gap_ge4", 32'(r_gap >= 4), 32'd1);
        do_frame(0, 1'b1, 7'h2B, 8'h44, 8'h96, 1'b0, 16'h0);
        chk("b2b_b_first_sen", 32'(r_first), 32'd1);
        chk("b2b_b_mosi", 32'(r_mosi), 32'hAB00);
        chk("b2b_b_rsp", 32'(r_rsp), 32'h96);

        // Reset in the middle of a read, during bit 7
        cmd_rw = 1'b1; cmd_addr = 7'h11; cmd_data = 8'h00; miso = 1'b1;
        cmd_valid0 = 1'b1;
        rises = 0; rv_seen = 0;
        begin
            logic p;
            p = sclk0;
            for (int n = 0; n < 300 && rises < 8; n++) begin
                @(posedge clk);
                #1;
                cmd_valid0 = 1'b0;
                if (sclk0 && !p) rises++;
                p = sclk0;
            end
        end
        chk("mid_reached_bit7", 32'(rises), 32'd8);
        chk("mid_sclk_high_before", 32'(sclk0), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_sen_now", 32'(sen0), 32'd1);
        chk("mid_sclk_now", 32'(sclk0), 32'd0);
        chk("mid_ready_now", 32'(ready0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid0) rv_seen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid0 || !sen0) rv_seen++;
        end
        chk("mid_no_rsp", 32'(rv_seen), 32'd0);
        do_frame(0, 1'b1, 7'h05, 8'h00, 8'h5A, 1'b0, 16'h0);
        chk("post_mid_mosi", 32'(r_mosi), 32'h8500);
        chk("post_mid_rsp", 32'(r_rsp), 32'h5A);
        chk("post_mid_latency", 32'(r_lat), 32'd140);

        // CLK_DIV=1 instance: write 7F/01
        do_frame(1, 1'b0, 7'h7F, 8'h01, 8'h00, 1'b0, 16'h0);
        chk("div1_mosi", 32'(r_mosi), 32'h7F01);
        chk("div1_sclk_pulses", 32'(r_nclk), 32'd16);
        chk("div1_period_min", 32'(r_pmin), 32'd2);
        chk("div1_period_max", 32'(r_pmax), 32'd2);
        chk("div1_sen_low", 32'(r_sen_low), 32'd34);
        chk("div1_latency", 32'(r_lat), 32'd35);
        chk("div1_no_rsp", 32'(r_nrsp), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
